crack_dispatcher: RTL and testbench

- Parametrised controller that runs NUM_ENG ARC4 crack engines in parallel. Each engine searches an interleaved slice of the key space.
- Launches all engines from a single en/rdy request and takes the first valid key found.
- Aborts the remaining engines, drains them, then reports key, key_valid and search cycle count to the board-level top.
- Replaces the single-engine start/wait sequencing at the top level.

---
 rtl/crack_dispatcher_if.sv | 33 +++
 rtl/crack_dispatcher.sv | 142 ++++++++++++++
 tb/tb_crack_dispatcher.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crack_dispatcher_if.sv
// Dispatcher bus: host start/result handshake plus per-engine control and results.
interface crack_dispatcher_if #(
    parameter int unsigned NUM_ENG = 2,
    parameter int unsigned KEY_W   = 24,
    parameter int unsigned CNT_W   = 32
);
    // Host side
    logic                     en;
    logic                     rdy;
    logic [KEY_W-1:0]         key;
    logic                     key_valid;
    logic [CNT_W-1:0]         cycles;
    logic [NUM_ENG-1:0]       busy_mask;
    // Engine side
    logic [NUM_ENG-1:0]       eng_en;
    logic [NUM_ENG-1:0]       eng_abort;
    logic [NUM_ENG*KEY_W-1:0] eng_base;
    logic [NUM_ENG-1:0]       eng_rdy;
    logic [NUM_ENG-1:0]       eng_key_valid;
    logic [NUM_ENG*KEY_W-1:0] eng_key;

    // Dispatcher view
    modport slave (
        input  en, eng_rdy, eng_key_valid, eng_key,
        output rdy, key, key_valid, cycles, busy_mask, eng_en, eng_abort, eng_base
    );

    // Host and engine-array view
    modport master (
        output en, eng_rdy, eng_key_valid, eng_key,
        input  rdy, key, key_valid, cycles, busy_mask, eng_en, eng_abort, eng_base
    );
endinterface

// File: rtl/crack_dispatcher.sv
// Launches NUM_ENG ARC4 crack engines together, keeps the first hit (lowest
// index on ties), aborts and drains the rest, and reports key and search time.
module crack_dispatcher #(
    parameter int unsigned NUM_ENG = 2,
    parameter int unsigned KEY_W   = 24,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    crack_dispatcher_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_ABORT,
        S_DRAIN
    } state_t;

    state_t               state, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic [CNT_W-1:0]     cycles_q, cycles_d;
    logic [NUM_ENG-1:0]   busy_q, busy_d;
    logic [NUM_ENG-1:0]   eng_en_q, eng_en_d;
    logic [NUM_ENG-1:0]   eng_abort_q, eng_abort_d;

    logic [NUM_ENG-1:0]   done_c;
    logic [NUM_ENG-1:0]   hit_c;
    logic [NUM_ENG-1:0]   remain_c;
    logic [KEY_W-1:0]     win_key_c;
    logic [CNT_W-1:0]     cycles_inc_c;
    logic                 rdy_c;

    // Engine completion, hits and the engines still outstanding afterwards
    assign done_c       = busy_q & bus.eng_rdy;
    assign hit_c        = done_c & bus.eng_key_valid;
    assign remain_c     = busy_q & ~done_c;
    assign cycles_inc_c = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
    assign rdy_c        = (state == S_IDLE) && (&bus.eng_rdy);

    // Lowest-index hitting engine supplies the key (descending scan, last write wins)
    always_comb begin
        win_key_c = '0;
        for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                win_key_c = bus.eng_key[i*KEY_W +: KEY_W];
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d     = state;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        cycles_d    = cycles_q;
        busy_d      = busy_q;
        eng_en_d    = '0;
        eng_abort_d = '0;
        case (state)
            S_IDLE: begin
                if (bus.en && rdy_c) begin
                    state_d     = S_LAUNCH;
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    cycles_d    = '0;
                    busy_d      = '1;
                    eng_en_d    = '1;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cycles_d = cycles_inc_c;
                busy_d   = remain_c;
                if (|hit_c) begin
                    key_d       = win_key_c;
                    key_valid_d = 1'b1;
                    eng_abort_d = remain_c;
                    state_d     = S_ABORT;
                end else if (remain_c == '0) begin
                    key_d       = '0;
                    key_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_ABORT: begin
                cycles_d = cycles_inc_c;
                busy_d   = remain_c;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                cycles_d = cycles_inc_c;
                busy_d   = remain_c;
                if (remain_c == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            cycles_q    <= '0;
            busy_q      <= '0;
            eng_en_q    <= '0;
            eng_abort_q <= '0;
        end else begin
            state       <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            cycles_q    <= cycles_d;
            busy_q      <= busy_d;
            eng_en_q    <= eng_en_d;
            eng_abort_q <= eng_abort_d;
        end
    end

    // Engine i starts its interleaved walk at key i
    for (genvar g = 0; g < int'(NUM_ENG); g++) begin : g_base
        assign bus.eng_base[g*KEY_W +: KEY_W] = KEY_W'(g);
    end

    assign bus.rdy       = rdy_c;
    assign bus.key       = key_q;
    assign bus.key_valid = key_valid_q;
    assign bus.cycles    = cycles_q;
    assign bus.busy_mask = busy_q;
    assign bus.eng_en    = eng_en_q;
    assign bus.eng_abort = eng_abort_q;

endmodule

// File: tb/tb_crack_dispatcher.sv
// Bench for crack_dispatcher: behavioural engine array, outcome predictor and
// scoreboard monitor; a second single-engine instance with a 4-bit counter.
module tb_crack_dispatcher;

    localparam int unsigned NE = 2;
    localparam int unsigned KW = 24;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crack_dispatcher_if #(.NUM_ENG(NE), .KEY_W(KW), .CNT_W(CW)) bus ();
    crack_dispatcher #(.NUM_ENG(NE), .KEY_W(KW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    crack_dispatcher_if #(.NUM_ENG(1), .KEY_W(KW), .CNT_W(4)) bus2 ();
    crack_dispatcher #(.NUM_ENG(1), .KEY_W(KW), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-search engine plan: busy length d, hit flag/key, abort latency a
    int              pl_d   [NE];
    int              pl_a   [NE];
    logic            pl_hit [NE];
    logic [KW-1:0]   pl_key [NE];

    typedef struct {
        logic [KW-1:0] key;
        logic          kv;
        int            d_end;
        int            comp [NE];
        logic [NE-1:0] amask;
    } exp_t;

    exp_t sbq[$];
    int   done_cnt = 0;

    // Outcome from the plan: cycle numbers count from 1 after the launch edge;
    // an engine busy for d cycles is seen complete in cycle d+1.
    function automatic exp_t predict();
        exp_t e;
        int   h;
        h       = 1 << 30;
        e.key   = '0;
        e.kv    = 1'b0;
        e.amask = '0;
        e.d_end = 0;
        for (int i = 0; i < NE; i++) begin
            if (pl_hit[i] && (pl_d[i] + 1 < h)) begin
                h     = pl_d[i] + 1;
                e.key = pl_key[i];
                e.kv  = 1'b1;
            end
        end
        for (int i = 0; i < NE; i++) begin
            if (!e.kv || (pl_d[i] + 1 <= h)) begin
                e.comp[i] = pl_d[i] + 1;
            end else begin
                e.comp[i]  = (pl_d[i] + 1 < h + 1 + pl_a[i]) ? pl_d[i] + 1 : h + 1 + pl_a[i];
                e.amask[i] = 1'b1;
            end
            if (e.comp[i] > e.d_end) e.d_end = e.comp[i];
        end
        if (e.kv && (e.d_end < h + 2)) e.d_end = h + 2;
        return e;
    endfunction

    // Behavioural engine array: outputs change 1 time unit after each rising edge
    logic [NE-1:0]    e_rdy = '1;
    logic [NE-1:0]    e_kv  = '0;
    logic [NE*KW-1:0] e_key = '0;
    assign bus.eng_rdy       = e_rdy;
    assign bus.eng_key_valid = e_kv;
    assign bus.eng_key       = e_key;

    initial begin
        logic [NE-1:0]    n_rdy;
        logic [NE-1:0]    n_kv;
        logic [NE*KW-1:0] n_key;
        bit               e_busy [NE];
        bit               e_ab   [NE];
        int               e_rem  [NE];
        int               e_abr  [NE];
        for (int i = 0; i < NE; i++) begin
            e_busy[i] = 0; e_ab[i] = 0; e_rem[i] = 0; e_abr[i] = 0;
        end
        forever begin
            @(negedge clk);
            n_rdy = e_rdy; n_kv = e_kv; n_key = e_key;
            for (int i = 0; i < NE; i++) begin
                if (!rst_n) begin
                    e_busy[i] = 0; e_ab[i] = 0;
                    n_rdy[i] = 1'b1; n_kv[i] = 1'b0;
                end else if (bus.eng_en[i]) begin
                    e_busy[i] = 1; e_ab[i] = 0; e_rem[i] = pl_d[i]; e_abr[i] = 0;
                    n_rdy[i] = 1'b0; n_kv[i] = 1'b0;
                end else if (e_busy[i]) begin
                    if (bus.eng_abort[i] && !e_ab[i]) begin
                        e_ab[i] = 1; e_abr[i] = pl_a[i];
                    end
                    e_rem[i]--;
                    if (e_ab[i]) e_abr[i]--;
                    if (e_rem[i] == 0) begin
                        e_busy[i] = 0; n_rdy[i] = 1'b1; n_kv[i] = pl_hit[i];
                        n_key[i*KW +: KW] = pl_hit[i] ? pl_key[i] : KW'($urandom);
                    end else if (e_ab[i] && e_abr[i] == 0) begin
                        e_busy[i] = 0; n_rdy[i] = 1'b1; n_kv[i] = 1'b0;
                        n_key[i*KW +: KW] = KW'($urandom);
                    end
                end
            end
            @(posedge clk);
            #1;
            e_rdy = n_rdy; e_kv = n_kv; e_key = n_key;
        end
    end

    // Scoreboard monitor: pops at launch, checks busy_mask every cycle, results at rdy
    logic [0:0] ab2_seen = '0;
    initial begin
        exp_t          cur;
        bit            in_s = 0;
        int            c = 0;
        int            pulses = 0;
        int            ab_cyc = 0;
        logic [NE-1:0] ab_or = '0;
        logic [NE-1:0] em;
        forever begin
            @(negedge clk);
            ab2_seen = ab2_seen | bus2.eng_abort;
            if (!rst_n) begin
                in_s = 0;
            end else if (!in_s) begin
                if (bus.eng_en != '0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_launch", 64'(bus.eng_en), 64'(0));
                    end else begin
                        cur = sbq.pop_front();
                        in_s = 1; c = 0; pulses = 1; ab_cyc = 0; ab_or = '0;
                        chk("launch_eng_en", 64'(bus.eng_en), 64'({NE{1'b1}}));
                        chk("launch_busy_mask", 64'(bus.busy_mask), 64'({NE{1'b1}}));
                        chk("launch_rdy", 64'(bus.rdy), 64'(0));
                    end
                end
            end else begin
                c++;
                if (bus.eng_en != '0) pulses++;
                if (bus.eng_abort != '0) begin
                    ab_cyc++;
                    ab_or = ab_or | bus.eng_abort;
                end
                chk("en_abort_overlap", 64'(bus.eng_en & bus.eng_abort), 64'(0));
                for (int i = 0; i < NE; i++) em[i] = (c <= cur.comp[i]);
                chk($sformatf("busy_mask_c%0d", c), 64'(bus.busy_mask), 64'(em));
                if (bus.rdy) begin
                    chk("key", 64'(bus.key), 64'(cur.key));
                    chk("key_valid", 64'(bus.key_valid), 64'(cur.kv));
                    chk("cycles", 64'(bus.cycles), 64'(cur.d_end));
                    chk("rdy_cycle", 64'(c), 64'(cur.d_end + 1));
                    chk("eng_en_pulses", 64'(pulses), 64'(1));
                    chk("abort_mask", 64'(ab_or), 64'(cur.amask));
                    chk("abort_cycles", 64'(ab_cyc), 64'((cur.amask != '0) ? 1 : 0));
                    in_s = 0;
                    done_cnt++;
                end else if (c > 3000) begin
                    chk("search_timeout", 64'(c), 64'(cur.d_end + 1));
                    in_s = 0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic set_plan(input int i, input int d, input bit hit, input logic [KW-1:0] k, input int a);
        pl_d[i] = d; pl_hit[i] = hit; pl_key[i] = k; pl_a[i] = a;
    endtask

    // Pulse en from an idle, ready dispatcher; returns in the LAUNCH cycle
    task automatic launch();
        int n = 0;
        while (!bus.rdy && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("rdy_before_launch", 64'(bus.rdy), 64'(1));
        bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
    endtask

    // Full search through the scoreboard; poke re-pulses en mid-run and on the exit cycle
    task automatic run(input bit poke);
        exp_t e;
        int   start;
        int   n = 0;
        e = predict();
        sbq.push_back(e);
        start = done_cnt;
        launch();
        if (poke) begin
            repeat (10) @(posedge clk);
            #1 bus.en = 1'b1;
            @(posedge clk); #1 bus.en = 1'b0;
            repeat (e.d_end - 11) @(posedge clk);
            #1 bus.en = 1'b1;
            @(posedge clk); #1 bus.en = 1'b0;
        end
        while (done_cnt == start && n < 5000) begin
            @(posedge clk); n++;
        end
        chk("search_completed", 64'(done_cnt != start), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0;
        bus2.en = 1'b0;
        bus2.eng_rdy = 1'b1;
        bus2.eng_key_valid = 1'b0;
        bus2.eng_key = '0;
        for (int i = 0; i < NE; i++) set_plan(i, 10, 1'b0, '0, 1);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key", 64'(bus.key), 64'(0));
        chk("rst_key_valid", 64'(bus.key_valid), 64'(0));
        chk("rst_cycles", 64'(bus.cycles), 64'(0));
        chk("rst_busy_mask", 64'(bus.busy_mask), 64'(0));
        chk("rst_eng_en", 64'(bus.eng_en), 64'(0));
        chk("rst_eng_abort", 64'(bus.eng_abort), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rdy", 64'(bus.rdy), 64'(1));
        for (int i = 0; i < NE; i++) begin
            logic [NE*KW-1:0] b;
            b = bus.eng_base;
            chk($sformatf("eng_base_%0d", i), 64'(b[i*KW +: KW]), 64'(i));
        end

        // Engine 1 hits 0x0B after 40 cycles; engine 0 runs long and drains slowly
        set_plan(0, 200, 1'b0, '0, 5);
        set_plan(1, 39, 1'b1, 24'h00000B, 1);
        run(0);

        // Simultaneous hits: lowest index wins, nothing left to abort
        set_plan(0, 20, 1'b1, 24'h000010, 2);
        set_plan(1, 20, 1'b1, 24'h000011, 2);
        run(0);

        // No hit, completions at cycles 100 and 120
        set_plan(0, 99, 1'b0, '0, 1);
        set_plan(1, 119, 1'b0, '0, 1);
        run(0);

        // en pulsed mid-run and on the return-to-idle cycle is ignored
        set_plan(0, 30, 1'b0, '0, 1);
        set_plan(1, 50, 1'b0, '0, 1);
        run(1);

        // Randomised searches
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NE; i++) begin
                set_plan(i, int'($urandom_range(1, 60)), 1'($urandom_range(0, 1)),
                         KW'(i + NE * $urandom_range(0, 5000)), int'($urandom_range(1, 6)));
            end
            run(0);
        end

        // Reset mid-run: outputs clear at once, no abort pulse, then a clean search
        set_plan(0, 80, 1'b0, '0, 1);
        set_plan(1, 80, 1'b1, 24'h000101, 1);
        sbq.push_back(predict());
        launch();
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cycles", 64'(bus.cycles), 64'(0));
        chk("midrst_busy_mask", 64'(bus.busy_mask), 64'(0));
        chk("midrst_key_valid", 64'(bus.key_valid), 64'(0));
        chk("midrst_eng_en", 64'(bus.eng_en), 64'(0));
        chk("midrst_eng_abort", 64'(bus.eng_abort), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sbq.delete();
        chk("midrst_no_abort_after", 64'(bus.eng_abort), 64'(0));
        set_plan(0, 15, 1'b1, 24'h000024, 1);
        set_plan(1, 25, 1'b0, '0, 3);
        run(0);

        // Single engine, 4-bit counter: 30-cycle miss saturates, short hit does not
        for (int s = 0; s < 2; s++) begin
            int d;
            int n;
            d = (s == 0) ? 30 : 5;
            n = 0;
            while (!bus2.rdy && n < 2000) begin
                @(posedge clk); #1; n++;
            end
            bus2.en = 1'b1;
            @(posedge clk); #1 bus2.en = 1'b0;
            chk("e1_launch_eng_en", 64'(bus2.eng_en), 64'(1));
            @(posedge clk); #1;
            bus2.eng_rdy = 1'b0;
            bus2.eng_key_valid = 1'b0;
            repeat (d) @(posedge clk);
            #1;
            bus2.eng_rdy = 1'b1;
            bus2.eng_key_valid = (s == 1);
            bus2.eng_key = (s == 1) ? 24'h00002A : 24'h000777;
            n = 0;
            while (!bus2.rdy && n < 2000) begin
                @(posedge clk); #1; n++;
            end
            chk("e1_rdy", 64'(bus2.rdy), 64'(1));
            chk("e1_cycles", 64'(bus2.cycles), 64'((s == 0) ? 15 : 8));
            chk("e1_key_valid", 64'(bus2.key_valid), 64'((s == 1) ? 1 : 0));
            chk("e1_key", 64'(bus2.key), 64'((s == 1) ? 24'h00002A : 24'h0));
            bus2.eng_key_valid = 1'b0;
        end
        chk("e1_no_abort", 64'(ab2_seen), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
